// File: rtl/bcd_score_accum.sv
// Multi-digit BCD score accumulator: weighted events, saturation, sticky win flag, RUN/OVER FSM.
// Optional high-score tracking is enabled by defining SCORE_HISCORE_EN.
module bcd_score_accum #(
    parameter int DIGITS      = 2,
    parameter int HIT_SCORE   = 1,
    parameter int BONUS_SCORE = 2,
    parameter int CHEAT_SCORE = 9,
    parameter int TARGET      = 99
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                newGame,
    input  logic                hit,
    input  logic                bonus,
    input  logic                scoreCheat,
    input  logic                gameOver,
    output logic [4*DIGITS-1:0] score,
    output logic                tc,
    output logic                saturated,
`ifdef SCORE_HISCORE_EN
    output logic [4*DIGITS-1:0] hiScore,
    output logic                newHigh,
`endif
    output logic                running
);

    function automatic longint pow10(int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(longint v);
        logic [31:0] r = '0;
        longint      t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [31:0] TGT_BCD32 = to_bcd(longint'(TARGET));

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_score_accum: DIGITS must be 2..8");
    end
    if (HIT_SCORE < 0 || HIT_SCORE > 9 || BONUS_SCORE < 0 || BONUS_SCORE > 9 ||
        CHEAT_SCORE < 0 || CHEAT_SCORE > 9) begin : g_bad_weights
        $error("bcd_score_accum: event weights must be 0..9");
    end
    if (TARGET < 1 || longint'(TARGET) > pow10(DIGITS) - 1) begin : g_bad_target
        $error("bcd_score_accum: TARGET out of range");
    end

    typedef enum logic {S_RUN = 1'b0, S_OVER = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   score_q, score_d, sum;
    logic                  tc_q, tc_d, sat_q, sat_d;
    logic [4:0]            inc;
    logic [3:0]            inc_tens, inc_units;
    logic                  carry_out, accept, go_over;

    assign accept  = (state_q == S_RUN) && !gameOver && !newGame;
    assign go_over = (state_q == S_RUN) && gameOver && !newGame;

    // Binary increment split into two BCD digits before entering the ripple chain.
    always_comb begin
        inc = (hit        ? 5'(HIT_SCORE)   : 5'd0)
            + (bonus      ? 5'(BONUS_SCORE) : 5'd0)
            + (scoreCheat ? 5'(CHEAT_SCORE) : 5'd0);
        if (inc >= 5'd20) begin
            inc_tens  = 4'd2;
            inc_units = 4'(inc - 5'd20);
        end else if (inc >= 5'd10) begin
            inc_tens  = 4'd1;
            inc_units = 4'(inc - 5'd10);
        end else begin
            inc_tens  = 4'd0;
            inc_units = inc[3:0];
        end
    end

    always_comb begin
        logic [4:0] s;
        logic [3:0] add;
        logic       c;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            add = (i == 0) ? inc_units : (i == 1) ? inc_tens : 4'd0;
            s   = {1'b0, score_q[4*i +: 4]} + {1'b0, add} + {4'd0, c};
            if (s >= 5'd10) begin
                sum[4*i +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                sum[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        carry_out = c;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= S_RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (newGame)      state_d = S_RUN;
        else if (go_over) state_d = S_OVER;
    end

    always_comb begin
        running = (state_q == S_RUN);
    end

    // Packed BCD compares like an unsigned integer, so the TARGET check is a plain >=.
    always_comb begin
        score_d = score_q;
        tc_d    = tc_q;
        sat_d   = sat_q;
        if (newGame) begin
            score_d = '0;
            tc_d    = 1'b0;
            sat_d   = 1'b0;
        end else if (accept) begin
            if (carry_out) begin
                score_d = {DIGITS{4'h9}};
                sat_d   = 1'b1;
            end else begin
                score_d = sum;
            end
            tc_d = tc_q | (score_d >= TGT_BCD32[4*DIGITS-1:0]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_q <= '0;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
        end
    end

    assign score     = score_q;
    assign tc        = tc_q;
    assign saturated = sat_q;

`ifdef SCORE_HISCORE_EN
    logic [4*DIGITS-1:0] hi_q, hi_d;
    logic                nh_q, nh_d;

    always_comb begin
        hi_d = hi_q;
        nh_d = nh_q;
        if (newGame) begin
            nh_d = 1'b0;
        end else if (go_over) begin
            if (score_q > hi_q) begin
                hi_d = score_q;
                nh_d = 1'b1;
            end else begin
                nh_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hi_q <= '0;
            nh_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            nh_q <= nh_d;
        end
    end

    assign hiScore = hi_q;
    assign newHigh = nh_q;
`endif

endmodule

// File: tb/tb_bcd_score_accum.sv
// Bench for bcd_score_accum: two instances (defaults, and DIGITS=3/TARGET=150) against a decimal model.
module tb_bcd_score_accum;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic newGame = 1'b0, hit = 1'b0, bonus = 1'b0, scoreCheat = 1'b0, gameOver = 1'b0;

    logic [7:0]  score0;
    logic [11:0] score1;
    logic        tc0, tc1, sat0, sat1, run0, run1;
`ifdef SCORE_HISCORE_EN
    logic [7:0]  hi0;
    logic [11:0] hi1;
    logic        nh0, nh1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_score_accum u0 (
        .clk(clk), .resetN(resetN), .newGame(newGame), .hit(hit), .bonus(bonus),
        .scoreCheat(scoreCheat), .gameOver(gameOver), .score(score0), .tc(tc0),
        .saturated(sat0),
`ifdef SCORE_HISCORE_EN
        .hiScore(hi0), .newHigh(nh0),
`endif
        .running(run0));

    bcd_score_accum #(.DIGITS(3), .TARGET(150)) u1 (
        .clk(clk), .resetN(resetN), .newGame(newGame), .hit(hit), .bonus(bonus),
        .scoreCheat(scoreCheat), .gameOver(gameOver), .score(score1), .tc(tc1),
        .saturated(sat1),
`ifdef SCORE_HISCORE_EN
        .hiScore(hi1), .newHigh(nh1),
`endif
        .running(run1));

    // Decimal reference model: scores are plain integers, converted to BCD only for comparison.
    int m_score[2], m_hi[2];
    bit m_tc[2], m_sat[2], m_run[2], m_nh[2];
    int MAXV[2] = '{99, 999};
    int TGT[2]  = '{99, 150};

    function automatic longint to_bcd(int v);
        longint r = 0;
        int t = v;
        for (int i = 0; i < 8; i++) begin
            r = r | (longint'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int inc_now(bit h, bit b, bit c);
        return (h ? 1 : 0) + (b ? 2 : 0) + (c ? 9 : 0);
    endfunction

    always @(posedge clk or negedge resetN) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetN) begin
                m_score[k] <= 0; m_tc[k] <= 0; m_sat[k] <= 0; m_run[k] <= 1;
                m_hi[k] <= 0; m_nh[k] <= 0;
            end else if (newGame) begin
                m_score[k] <= 0; m_tc[k] <= 0; m_sat[k] <= 0; m_run[k] <= 1; m_nh[k] <= 0;
            end else if (m_run[k] && gameOver) begin
                m_run[k] <= 0;
                if (m_score[k] > m_hi[k]) begin
                    m_hi[k] <= m_score[k]; m_nh[k] <= 1;
                end else begin
                    m_nh[k] <= 0;
                end
            end else if (m_run[k]) begin
                m_score[k] <= clamp(m_score[k] + inc_now(hit, bonus, scoreCheat), MAXV[k]);
                if (m_score[k] + inc_now(hit, bonus, scoreCheat) > MAXV[k]) m_sat[k] <= 1;
                if (clamp(m_score[k] + inc_now(hit, bonus, scoreCheat), MAXV[k]) >= TGT[k])
                    m_tc[k] <= 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            chk("score0", score0, to_bcd(m_score[0]));
            chk("tc0", tc0, m_tc[0]);
            chk("sat0", sat0, m_sat[0]);
            chk("run0", run0, m_run[0]);
            chk("score1", score1, to_bcd(m_score[1]));
            chk("tc1", tc1, m_tc[1]);
            chk("sat1", sat1, m_sat[1]);
            chk("run1", run1, m_run[1]);
`ifdef SCORE_HISCORE_EN
            chk("hi0", hi0, to_bcd(m_hi[0]));
            chk("nh0", nh0, m_nh[0]);
            chk("hi1", hi1, to_bcd(m_hi[1]));
            chk("nh1", nh1, m_nh[1]);
`endif
        end
    end

    // One call drives one cycle of inputs, set just after the falling edge.
    task automatic cyc(input bit h, input bit b, input bit c, input bit go, input bit ng);
        @(negedge clk);
        #1;
        hit = h; bonus = b; scoreCheat = c; gameOver = go; newGame = ng;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic rep(input int n, input bit h, input bit b, input bit c);
        for (int i = 0; i < n; i++) cyc(h, b, c, 0, 0);
    endtask

    initial begin
        #12;
        chk("rst_score0", score0, 8'h00);
        chk("rst_run0", run0, 1'b1);
        chk("rst_tc0", tc0, 1'b0);
        chk("rst_sat0", sat0, 1'b0);
        @(negedge clk); #1 resetN = 1'b1;

        for (int i = 0; i < 5; i++) begin cyc(1, 0, 0, 0, 0); idle(); end
        chk("five_hits", score0, 8'h05);
        chk("five_hits_tc", tc0, 1'b0);

        rep(3, 1, 0, 0);
        cyc(1, 1, 0, 0, 0); idle();
        chk("carry0", score0, 8'h11);
        chk("carry1", score1, 12'h011);

        rep(9, 0, 0, 1); rep(3, 1, 0, 0); idle();
        chk("pre_sat", score0, 8'h95);
        cyc(1, 1, 1, 0, 0); idle();
        chk("sat_score0", score0, 8'h99);
        chk("sat_flag0", sat0, 1'b1);
        chk("sat_tc0", tc0, 1'b1);
        chk("no_sat_score1", score1, 12'h107);
        chk("no_sat_tc1", tc1, 1'b0);
        rep(2, 1, 0, 0); idle();
        chk("sat_hold0", score0, 8'h99);

        cyc(0, 0, 0, 0, 1);
        rep(16, 0, 0, 1); rep(5, 1, 0, 0); idle();
        chk("d3_149", score1, 12'h149);
        chk("d3_149_tc", tc1, 1'b0);
        cyc(1, 0, 0, 0, 0); idle();
        chk("d3_150", score1, 12'h150);
        chk("d3_150_tc", tc1, 1'b1);
        cyc(0, 1, 0, 0, 0); idle();
        chk("d3_152", score1, 12'h152);
        chk("d3_152_tc", tc1, 1'b1);

        cyc(0, 0, 0, 0, 1);
        rep(4, 0, 0, 1); rep(2, 0, 1, 0); idle();
        chk("pre_over", score0, 8'h40);
        cyc(1, 0, 0, 1, 0); idle();
        chk("over_score", score0, 8'h40);
        chk("over_run", run0, 1'b0);
        rep(3, 1, 0, 0); idle();
        chk("over_ignore", score0, 8'h40);
        cyc(1, 0, 0, 0, 1); idle();
        chk("ng_score", score0, 8'h00);
        chk("ng_run", run0, 1'b1);
        chk("ng_tc", tc0, 1'b0);
        chk("ng_sat", sat0, 1'b0);

        rep(6, 0, 0, 1); rep(3, 1, 0, 0); idle();
        chk("pre_arst", score0, 8'h57);
        @(negedge clk); #2 resetN = 1'b0;
        #1;
        chk("arst_score0", score0, 8'h00);
        chk("arst_score1", score1, 12'h000);
        chk("arst_tc", tc0, 1'b0);
        chk("arst_run", run0, 1'b1);
        @(negedge clk); #1 resetN = 1'b1;

`ifdef SCORE_HISCORE_EN
        rep(3, 0, 0, 1); rep(3, 1, 0, 0);
        cyc(0, 0, 0, 1, 0); idle();
        chk("hi_first", hi0, 8'h30);
        chk("nh_first", nh0, 1'b1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0); idle();
        chk("hi_keep", hi0, 8'h30);
        chk("nh_clear", nh0, 1'b0);
        cyc(0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 59) == 0));
        end
        idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
